lap_stopwatch: RTL

Parametrised sport stopwatch with lap memory, the next generation of the team's `sportstopwatch`. It counts mm:ss.cc from a prescaled system clock and drives six 7-segment digits plus red/green status LEDs. It also stores up to `LAP_DEPTH` lap times in an on-chip register file for later recall. It sits between the debounced board buttons and the seven-segment display driver.

---
 rtl/lap_stopwatch.sv | 335 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lap_stopwatch.sv
// lap_stopwatch
//
// Sport stopwatch that counts mm:ss.cc from a prescaled system clock. It
// drives six 7-segment digits and red/green status LEDs, and keeps up to
// LAP_DEPTH lap times for later recall.
//
// Parameters:
//   CLK_DIV   clk cycles per centisecond tick (>= 2)
//   LAP_DEPTH number of lap entries (>= 1)
//   CW        width of lap_count
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   btn[3:0]   debounced level inputs: [0] start/stop, [1] lap/reset,
//              [2] recall next, [3] clear laps
//   a5..a0     registered segments (gfedcba, active-high), a5:a4 minutes,
//              a3:a2 seconds, a1:a0 centiseconds
//   newclk     one-cycle centisecond tick pulse while running
//   green/red  status LEDs (IDLE 0/0, RUN 1/0, STOP 0/1, RECALL 1/1)
//   lap_count  number of stored laps
//   lap_full   lap_count == LAP_DEPTH
//
// Build option:
//   LAP_SPLIT_EN  when defined, a lap entry holds the split time since the
//                 previous lap press instead of the cumulative time.

module lap_stopwatch #(
    parameter int CLK_DIV   = 4,
    parameter int LAP_DEPTH = 4,
    parameter int CW        = $clog2(LAP_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    btn,
    output logic [6:0]    a0,
    output logic [6:0]    a1,
    output logic [6:0]    a2,
    output logic [6:0]    a3,
    output logic [6:0]    a4,
    output logic [6:0]    a5,
    output logic          newclk,
    output logic          green,
    output logic          red,
    output logic [CW-1:0] lap_count,
    output logic          lap_full
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, STOP, RECALL} state_t;

    state_t        state;
    state_t        state_next;
    logic          entry_stop;
    logic [3:0]    btn_q;
    logic [3:0]    press;
    logic          do_clr;
    logic          do_lap;
    logic          do_ss;
    logic          do_rec;
    logic          has_laps;
    logic          rec_enter;
    logic          lap_wr;
    logic          clear_time;
    logic [PW-1:0] pre;
    logic          tick;
    logic [23:0]   tm;
    logic [23:0]   lap_val;
    logic [23:0]   disp;
    logic [IW-1:0] rec_idx;
    logic [23:0]   laps [LAP_DEPTH];

    // Highest legal value of BCD digit i (digits 3 and 5 are the tens of
    // seconds and minutes, which only go up to 5).
    function automatic logic [3:0] last_digit(input int i);
        return (i == 3 || i == 5) ? 4'd5 : 4'd9;
    endfunction

    // Add one centisecond to a packed six-digit BCD time, rolling over from
    // 59:59.99 to 00:00.00.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        c;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (t[i*4 +: 4] == last_digit(i)) begin
                    r[i*4 +: 4] = 4'd0;
                    c = 1'b1;
                end else begin
                    r[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Map one BCD digit onto gfedcba segment lines; non-decimal codes blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Button presses are rising edges. Only the highest-priority press of a
    // cycle is honoured: clear laps, then lap/reset, then start/stop, then
    // recall.
    assign press      = btn & ~btn_q;
    assign do_clr     = press[3];
    assign do_lap     = press[1] & ~press[3];
    assign do_ss      = press[0] & ~press[1] & ~press[3];
    assign do_rec     = press[2] & ~press[0] & ~press[1] & ~press[3];

    assign has_laps   = (lap_count != '0);
    assign lap_full   = (lap_count == CW'(LAP_DEPTH));
    assign rec_enter  = ((state == IDLE) || (state == STOP)) && do_rec && has_laps;
    assign lap_wr     = (state == RUN) && do_lap && !lap_full;
    assign clear_time = (state == STOP) && do_lap;
    assign tick       = (state == RUN) && (pre == PW'(CLK_DIV - 1));
    assign newclk     = tick;

    // Previous button levels, used for edge detection. Clearing this on reset
    // means a button held through reset counts as one press afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 4'b0000;
        end else begin
            btn_q <= btn;
        end
    end

    // State register, plus a note of which state RECALL was entered from so
    // that leaving RECALL can return there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            entry_stop <= 1'b0;
        end else begin
            state <= state_next;
            if (rec_enter) begin
                entry_stop <= (state == STOP);
            end
        end
    end

    // Next-state decision from the single press selected this cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (do_ss) begin
                    state_next = RUN;
                end else if (rec_enter) begin
                    state_next = RECALL;
                end
            end
            RUN: begin
                if (do_ss) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (do_ss) begin
                    state_next = RUN;
                end else if (do_lap) begin
                    state_next = IDLE;
                end else if (rec_enter) begin
                    state_next = RECALL;
                end
            end
            RECALL: begin
                if (do_clr || do_ss) begin
                    state_next = entry_stop ? STOP : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Status LEDs decoded straight from the state.
    always_comb begin
        green = 1'b0;
        red   = 1'b0;
        case (state)
            RUN:     green = 1'b1;
            STOP:    red   = 1'b1;
            RECALL: begin
                green = 1'b1;
                red   = 1'b1;
            end
            default: begin
                green = 1'b0;
                red   = 1'b0;
            end
        endcase
    end

    // Centisecond prescaler. It only advances while running, so a stop keeps
    // the partial count for the next start; returning to IDLE zeroes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (clear_time) begin
            pre <= '0;
        end else if (state == RUN) begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    // Live BCD time. The tick is taken from the current state, so a stop
    // press landing on a tick still lets that last centisecond count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tm <= '0;
        end else if (clear_time) begin
            tm <= '0;
        end else if (tick) begin
            tm <= bcd_inc(tm);
        end
    end

`ifdef LAP_SPLIT_EN
    logic [23:0] prev_ts;

    // Digit-wise BCD subtraction with borrow. The final borrow out of the
    // minutes tens is dropped, which gives minutes modulo 60.
    function automatic logic [23:0] bcd_sub(input logic [23:0] a, input logic [23:0] b);
        logic [23:0] r;
        logic [4:0]  d;
        logic        br;
        r  = '0;
        br = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = {1'b0, a[i*4 +: 4]} - {1'b0, b[i*4 +: 4]} - {4'b0000, br};
            if (d[4]) begin
                d  = d + {1'b0, last_digit(i)} + 5'd1;
                br = 1'b1;
            end else begin
                br = 1'b0;
            end
            r[i*4 +: 4] = d[3:0];
        end
        return r;
    endfunction

    // Time of the last stored lap; the split is measured from here. It
    // starts over from zero in IDLE and whenever the laps are cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ts <= '0;
        end else if (do_clr || clear_time) begin
            prev_ts <= '0;
        end else if (lap_wr) begin
            prev_ts <= tm;
        end
    end

    assign lap_val = bcd_sub(tm, prev_ts);
`else
    assign lap_val = tm;
`endif

    // Lap counter. Presses once full are dropped so stored laps are never
    // overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_count <= '0;
        end else if (do_clr) begin
            lap_count <= '0;
        end else if (lap_wr) begin
            lap_count <= lap_count + CW'(1);
        end
    end

    // Lap register file. Contents need no reset because only entries below
    // lap_count are ever shown. The value written is the time before any
    // tick in the same cycle.
    always_ff @(posedge clk) begin
        if (lap_wr) begin
            laps[lap_count[IW-1:0]] <= lap_val;
        end
    end

    // Recall index: zero on entering RECALL, then stepping through the
    // stored laps and wrapping after the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_idx <= '0;
        end else if (rec_enter) begin
            rec_idx <= '0;
        end else if ((state == RECALL) && do_rec) begin
            if (CW'(rec_idx) + CW'(1) == lap_count) begin
                rec_idx <= '0;
            end else begin
                rec_idx <= rec_idx + IW'(1);
            end
        end
    end

    assign disp = (state == RECALL) ? laps[rec_idx] : tm;

    // Registered segment drivers, one cycle behind the time and index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a0 <= 7'b0111111;
            a1 <= 7'b0111111;
            a2 <= 7'b0111111;
            a3 <= 7'b0111111;
            a4 <= 7'b0111111;
            a5 <= 7'b0111111;
        end else begin
            a0 <= seg7(disp[3:0]);
            a1 <= seg7(disp[7:4]);
            a2 <= seg7(disp[11:8]);
            a3 <= seg7(disp[15:12]);
            a4 <= seg7(disp[19:16]);
            a5 <= seg7(disp[23:20]);
        end
    end

endmodule
